// File: rtl/pci_target_responder.sv
// PCI memory target with a 16-word register file in a 64-byte window.
// It decodes memory read/write commands and supports zero-wait-state bursts.
module pci_target_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int unsigned MEM_WORDS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        FRAME_,
    input  logic        IRDY_,
    input  logic [3:0]  C_BE_,
    input  logic [31:0] AD_in,
    output logic [31:0] AD_out,
    output logic        AD_oe,
    output logic        DEVSEL_,
    output logic        TRDY_
);
    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam logic [3:0] CMD_MEM_RD = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR = 4'b0111;

    typedef enum logic [1:0] {IDLE, RD_TURN, DATA_RD, DATA_WR} state_t;

    state_t            state;
    logic              frame_q;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic [31:0]       mem [MEM_WORDS];
    logic [31:0]       wr_data;
    logic              addr_phase;
    logic              hit;
    logic              xfer;

    assign addr_phase = !FRAME_ && frame_q;
    assign hit        = (AD_in[31:6] == BASE_ADDR[31:6]) &&
                        ((C_BE_ == CMD_MEM_RD) || (C_BE_ == CMD_MEM_WR));
    assign xfer       = !IRDY_ && !TRDY_;
    assign idx_next   = idx + IDX_W'(1);

    // Merge enabled bytes of the bus into the currently addressed word
    always_comb begin
        wr_data = mem[idx];
        for (int i = 0; i < 4; i++) begin
            if (!C_BE_[i]) wr_data[8*i +: 8] = AD_in[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            frame_q <= 1'b1;
            idx     <= '0;
            AD_out  <= '0;
            AD_oe   <= 1'b0;
            DEVSEL_ <= 1'b1;
            TRDY_   <= 1'b1;
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
        end else begin
            frame_q <= FRAME_;
            case (state)
                IDLE: begin
                    if (addr_phase && hit) begin
                        idx     <= AD_in[5:2];
                        DEVSEL_ <= 1'b0;
                        if (C_BE_ == CMD_MEM_WR) begin
                            TRDY_ <= 1'b0;
                            state <= DATA_WR;
                        end else begin
                            state <= RD_TURN;
                        end
                    end
                end
                RD_TURN: begin
                    if (FRAME_ && IRDY_) begin
                        state   <= IDLE;
                        DEVSEL_ <= 1'b1;
                        TRDY_   <= 1'b1;
                        AD_oe   <= 1'b0;
                        AD_out  <= '0;
                    end else begin
                        AD_oe  <= 1'b1;
                        AD_out <= mem[idx];
                        TRDY_  <= 1'b0;
                        state  <= DATA_RD;
                    end
                end
                DATA_RD: begin
                    // Last data phase or abort both release the bus
                    if (FRAME_ && (xfer || IRDY_)) begin
                        state   <= IDLE;
                        DEVSEL_ <= 1'b1;
                        TRDY_   <= 1'b1;
                        AD_oe   <= 1'b0;
                        AD_out  <= '0;
                    end else if (xfer) begin
                        idx    <= idx_next;
                        AD_out <= mem[idx_next];
                    end
                end
                DATA_WR: begin
                    if (xfer) mem[idx] <= wr_data;
                    if (FRAME_ && (xfer || IRDY_)) begin
                        state   <= IDLE;
                        DEVSEL_ <= 1'b1;
                        TRDY_   <= 1'b1;
                        AD_oe   <= 1'b0;
                        AD_out  <= '0;
                    end else if (xfer) begin
                        idx <= idx_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pci_target_responder.sv
// Directed bench for pci_target_responder: single/burst reads and writes,
// byte enables, decode misses, wait states and mid-burst reset.
module tb_pci_target_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        FRAME_;
    logic        IRDY_;
    logic [3:0]  C_BE_;
    logic [31:0] AD_in;
    logic [31:0] AD_out;
    logic        AD_oe;
    logic        DEVSEL_;
    logic        TRDY_;

    int tests = 0;
    int fails = 0;

    pci_target_responder #(.BASE_ADDR(32'h0000_1000), .MEM_WORDS(16)) dut (
        .clk(clk), .reset(reset), .FRAME_(FRAME_), .IRDY_(IRDY_), .C_BE_(C_BE_),
        .AD_in(AD_in), .AD_out(AD_out), .AD_oe(AD_oe), .DEVSEL_(DEVSEL_), .TRDY_(TRDY_)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic dev, input logic trdy, input logic oe);
        chk({tag, ".devsel"}, 32'(DEVSEL_), 32'(dev));
        chk({tag, ".trdy"},   32'(TRDY_),   32'(trdy));
        chk({tag, ".ad_oe"},  32'(AD_oe),   32'(oe));
    endtask

    // Advance one edge and sample just after it, checking bus invariants
    task automatic step();
        @(posedge clk);
        #1;
        if (TRDY_ === 1'b0) chk("inv.trdy_without_devsel", 32'(DEVSEL_), 32'd0);
        if (AD_oe === 1'b1) chk("inv.ad_out_known", 32'($isunknown(AD_out)), 32'd0);
    endtask

    task automatic idle(input int n);
        FRAME_ = 1'b1; IRDY_ = 1'b1; C_BE_ = 4'hF; AD_in = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic addr(input logic [31:0] a, input logic [3:0] cmd);
        FRAME_ = 1'b0; IRDY_ = 1'b1; AD_in = a; C_BE_ = cmd;
        step();
    endtask

    task automatic single_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] be);
        addr(a, 4'b0111);
        chk_outs({tag, ".addr"}, 1'b0, 1'b0, 1'b0);
        FRAME_ = 1'b1; IRDY_ = 1'b0; AD_in = d; C_BE_ = be;
        step();
        chk_outs({tag, ".done"}, 1'b1, 1'b1, 1'b0);
        idle(1);
    endtask

    task automatic single_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr(a, 4'b0110);
        chk_outs({tag, ".turn"}, 1'b0, 1'b1, 1'b0);
        FRAME_ = 1'b1; IRDY_ = 1'b0; C_BE_ = 4'h0; AD_in = '0;
        step();
        chk_outs({tag, ".data"}, 1'b0, 1'b0, 1'b1);
        chk({tag, ".ad_out"}, AD_out, exp);
        step();
        chk_outs({tag, ".done"}, 1'b1, 1'b1, 1'b0);
        idle(1);
    endtask

    initial begin
        reset = 1'b1;
        FRAME_ = 1'b1; IRDY_ = 1'b1; C_BE_ = 4'hF; AD_in = '0;
        step(); step();
        chk_outs("reset", 1'b1, 1'b1, 1'b0);
        chk("reset.ad_out", AD_out, 32'h0);
        reset = 1'b0;
        idle(2);

        // Single write, then read back, then partial byte write
        single_write("wr1", 32'h0000_1004, 32'hDEAD_BEEF, 4'b0000);
        chk("wr1.mem1", dut.mem[1], 32'hDEAD_BEEF);
        single_read("rd1", 32'h0000_1004, 32'hDEAD_BEEF);
        single_write("wrbe", 32'h0000_1004, 32'h1234_5678, 4'b1010);
        single_read("rdbe", 32'h0000_1004, 32'hDE34_BE78);

        // Out-of-window address and non-memory command must be ignored
        addr(32'h0000_2000, 4'b0111);
        chk_outs("miss_addr.addr", 1'b1, 1'b1, 1'b0);
        FRAME_ = 1'b1; IRDY_ = 1'b0; AD_in = 32'hFFFF_FFFF; C_BE_ = 4'h0;
        step();
        chk_outs("miss_addr.data", 1'b1, 1'b1, 1'b0);
        idle(1);
        addr(32'h0000_1004, 4'b0010);
        chk_outs("miss_cmd.addr", 1'b1, 1'b1, 1'b0);
        FRAME_ = 1'b1; IRDY_ = 1'b0; AD_in = 32'hFFFF_FFFF; C_BE_ = 4'h0;
        step();
        chk_outs("miss_cmd.data", 1'b1, 1'b1, 1'b0);
        idle(1);
        single_read("miss.w0", 32'h0000_1000, 32'h0);
        single_read("miss.w1", 32'h0000_1004, 32'hDE34_BE78);

        // Burst write of words 14,15,0,1
        addr(32'h0000_1038, 4'b0111);
        chk_outs("bw.addr", 1'b0, 1'b0, 1'b0);
        FRAME_ = 1'b0; IRDY_ = 1'b0; C_BE_ = 4'h0;
        AD_in = 32'h1111_000E; step();
        chk_outs("bw.d0", 1'b0, 1'b0, 1'b0);
        AD_in = 32'h2222_000F; step();
        AD_in = 32'h3333_0000; step();
        FRAME_ = 1'b1;
        AD_in = 32'h4444_0001; step();
        chk_outs("bw.done", 1'b1, 1'b1, 1'b0);
        chk("bw.mem15", dut.mem[15], 32'h2222_000F);
        chk("bw.mem0", dut.mem[0], 32'h3333_0000);
        idle(1);

        // Burst read with one initiator wait state, wrapping 15 -> 0
        addr(32'h0000_1038, 4'b0110);
        chk_outs("br.turn", 1'b0, 1'b1, 1'b0);
        FRAME_ = 1'b0; IRDY_ = 1'b0; C_BE_ = 4'h0; AD_in = '0;
        step();
        chk("br.w14", AD_out, 32'h1111_000E);
        chk_outs("br.w14", 1'b0, 1'b0, 1'b1);
        step();
        chk("br.w15", AD_out, 32'h2222_000F);
        IRDY_ = 1'b1; step();
        chk("br.wait", AD_out, 32'h2222_000F);
        chk_outs("br.wait", 1'b0, 1'b0, 1'b1);
        IRDY_ = 1'b0; step();
        chk("br.w0", AD_out, 32'h3333_0000);
        step();
        chk("br.w1", AD_out, 32'h4444_0001);
        FRAME_ = 1'b1; step();
        chk_outs("br.done", 1'b1, 1'b1, 1'b0);
        idle(1);

        // Reset asserted mid read burst
        addr(32'h0000_1038, 4'b0110);
        FRAME_ = 1'b0; IRDY_ = 1'b0; C_BE_ = 4'h0;
        step(); step();
        chk("rst_burst.pre", AD_out, 32'h2222_000F);
        #2 reset = 1'b1;
        #1;
        chk_outs("rst_burst", 1'b1, 1'b1, 1'b0);
        chk("rst_burst.ad_out", AD_out, 32'h0);
        for (int i = 0; i < 16; i++) chk($sformatf("rst_burst.mem%0d", i), dut.mem[i], 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);
        single_read("post_rst.w0", 32'h0000_1000, 32'h0);
        single_read("post_rst.w14", 32'h0000_1038, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
